// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
// Holds the FSM encoding and the round-robin index search.
package axis_rr_arbiter_pkg;

  localparam int RR_MAX_SRC = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First requesting index after 'last', wrapping modulo n.
  // Returns 'last' when nothing requests.
  function automatic int rr_next(
    input logic [RR_MAX_SRC-1:0] req,
    input int                    last,
    input int                    n
  );
    int r;
    int k;
    r = last;
    for (int i = RR_MAX_SRC; i >= 1; i--) begin
      k = last + i;
      if (k >= n) k = k - n;
      if (i <= n && req[4'(k)]) r = k;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Source-side and merged-side stream signals of the arbiter.
// master: arbiter view, slave: producers/consumer view.
interface axis_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int SRC_WIDTH  = 2
);

  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC-1:0]            s_axis_tlast;
  logic [NUM_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic [SRC_WIDTH-1:0]          m_axis_tuser;
  logic                          m_axis_tready;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output m_axis_tuser,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  m_axis_tuser,
    output m_axis_tready
  );

endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational rotate-and-priority-encode picker.
// Finds the next requester after the last grant, with wrap.
module axis_rr_arbiter_rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int SRC_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_WIDTH-1:0] last,
  output logic [SRC_WIDTH-1:0] idx,
  output logic                 vld
);

  assign idx = SRC_WIDTH'(rr_next(RR_MAX_SRC'(req),
                                  int'(last), NUM_SRC));
  assign vld = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of NUM_SRC streams into one registered
// stream; grant held until tlast or MAX_BURST words.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int SRC_WIDTH  = 2,
  parameter int MAX_BURST  = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  axis_rr_arbiter_if.master    bus,
  input  logic [NUM_SRC-1:0]   cfg_enable,
  output logic [SRC_WIDTH-1:0] sts_grant,
  output logic                 sts_busy
);

  localparam logic [15:0] BURST_END = 16'(MAX_BURST - 1);

  state_t                state_q;
  state_t                state_d;
  logic [SRC_WIDTH-1:0]  grant_q;
  logic [SRC_WIDTH-1:0]  pick_idx;
  logic                  pick_vld;
  logic [15:0]           burst_q;
  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    tready;
  logic                  xfer;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [SRC_WIDTH-1:0]  tuser_q;
  logic                  tvalid_q;
  logic                  tlast_q;

  assign req = bus.s_axis_tvalid & cfg_enable;

  axis_rr_arbiter_rr_pick #(
    .NUM_SRC   (NUM_SRC),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_rr_pick (
    .req  (req),
    .last (grant_q),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign xfer    = bus.s_axis_tvalid[grant_q] & tready[grant_q];
  assign is_last = bus.s_axis_tlast[grant_q]
                 | (burst_q == BURST_END);

  // state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: arbitrate in IDLE, release on last word
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_vld) state_d = GRANT;
      GRANT:   if (xfer && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: only the granted source sees ready
  always_comb begin
    tready   = '0;
    sts_busy = 1'b0;
    if (state_q == GRANT) begin
      tready[grant_q] = ~tvalid_q | bus.m_axis_tready;
      sts_busy        = 1'b1;
    end
  end

  // grant index and per-grant word counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant_q <= SRC_WIDTH'(NUM_SRC - 1);
      burst_q <= '0;
    end else if (state_q == IDLE && pick_vld) begin
      grant_q <= pick_idx;
      burst_q <= '0;
    end else if (xfer) begin
      burst_q <= is_last ? '0 : burst_q + 16'd1;
    end
  end

  // output register: load on accept, clear valid on drain
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
    end else if (xfer) begin
      tvalid_q <= 1'b1;
      tlast_q  <= is_last;
      tdata_q  <= bus.s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      tuser_q  <= grant_q;
    end else if (bus.m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tuser  = tuser_q;
  assign sts_grant         = grant_q;

endmodule
